cmd_regs_bridge: RTL and testbench

CMD_REGS_BRIDGE -- requirements
Module: cmd_regs_bridge

---
 rtl/cmd_regs_bridge.sv | 176 +++++++++++++++++
 tb/tb_cmd_regs_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_regs_bridge.sv
// Byte-stream command bridge to a simple register-memory master port.
// Optional abort-on-timeout in the wait states is enabled by defining CMD_BRIDGE_TIMEOUT_EN.
module cmd_regs_bridge #(
    parameter int DATA_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int ADDR_WIDTH    = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  write_en,
    output logic                  read_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [7:0]            write_data,
    input  logic [7:0]            read_data,
    input  logic                  data_ready,
    input  logic                  write_done,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        WRITE,
        WAIT_WDONE,
        READ,
        WAIT_RDATA,
        SEND
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            write_data_q, write_data_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  write_en_q, write_en_d;
    logic                  read_en_q, read_en_d;
    logic                  busy_q, busy_d;
    logic                  rx_accept;
    logic                  timeout;

    // Command bits between the address field and bit 7 carry no meaning.
    logic unused_rx_bits;
    assign unused_rx_bits = ^rx_data;

`ifdef CMD_BRIDGE_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;

    // Counts from the first strobe cycle so the request is outstanding
    // for exactly TIMEOUT_CYCLES cycles before the abort.
    always_comb begin
        timer_d = '0;
        if (state_q inside {WRITE, WAIT_WDONE, READ, WAIT_RDATA}) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    assign timeout = (state_q inside {WAIT_WDONE, WAIT_RDATA}) && (timer_q == TIMER_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
`endif

    assign rx_accept = rx_valid && rx_ready_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        write_data_d = write_data_q;
        tx_data_d    = tx_data_q;

        unique case (state_q)
            IDLE: begin
                if (rx_accept) begin
                    addr_d  = rx_data[ADDR_WIDTH-1:0];
                    state_d = rx_data[7] ? GET_DATA : READ;
                end
            end
            GET_DATA: begin
                if (rx_accept) begin
                    write_data_d = rx_data;
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                state_d = WAIT_WDONE;
            end
            WAIT_WDONE: begin
                if (write_done) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    tx_data_d = 8'hEE;
                    state_d   = SEND;
                end
            end
            READ, WAIT_RDATA: begin
                if (data_ready) begin
                    tx_data_d = read_data;
                    state_d   = SEND;
                end else if (timeout) begin
                    tx_data_d = 8'hEE;
                    state_d   = SEND;
                end else begin
                    state_d = WAIT_RDATA;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so each flop lines up with state_q.
        rx_ready_d = (state_d == IDLE) || (state_d == GET_DATA);
        write_en_d = (state_d == WRITE);
        read_en_d  = (state_d == READ) || (state_d == WAIT_RDATA);
        tx_valid_d = (state_d == SEND);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            write_data_q <= '0;
            tx_data_q    <= '0;
            rx_ready_q   <= 1'b0;
            tx_valid_q   <= 1'b0;
            write_en_q   <= 1'b0;
            read_en_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            write_data_q <= write_data_d;
            tx_data_q    <= tx_data_d;
            rx_ready_q   <= rx_ready_d;
            tx_valid_q   <= tx_valid_d;
            write_en_q   <= write_en_d;
            read_en_q    <= read_en_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign write_en   = write_en_q;
    assign read_en    = read_en_q;
    assign addr       = addr_q;
    assign write_data = write_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_cmd_regs_bridge.sv
// Directed-vector bench for cmd_regs_bridge; define CMD_BRIDGE_TIMEOUT_EN to also exercise the abort path.
module tb_cmd_regs_bridge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       write_en;
    logic       read_en;
    logic [3:0] addr;
    logic [7:0] write_data;
    logic [7:0] read_data;
    logic       data_ready;
    logic       write_done;
    logic       busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned both_cnt = 0;
    int unsigned wr_cycles = 0;

`ifdef CMD_BRIDGE_TIMEOUT_EN
    localparam int unsigned EXP_WR_CYCLES = 2;
`else
    localparam int unsigned EXP_WR_CYCLES = 1;
`endif

    cmd_regs_bridge #(
        .DATA_DEPTH    (16),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .write_en  (write_en),
        .read_en   (read_en),
        .addr      (addr),
        .write_data(write_data),
        .read_data (read_data),
        .data_ready(data_ready),
        .write_done(write_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (write_en && read_en) both_cnt++;
        if (write_en) wr_cycles++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic done;
        done     = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (rx_ready) begin
                tick();
                done = 1'b1;
                break;
            end
            tick();
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        if (!done) check_eq("rx_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_write_en"},   write_en,   0);
        check_eq({tag, "_read_en"},    read_en,    0);
        check_eq({tag, "_tx_valid"},   tx_valid,   0);
        check_eq({tag, "_busy"},       busy,       0);
        check_eq({tag, "_addr"},       addr,       0);
        check_eq({tag, "_write_data"}, write_data, 0);
        check_eq({tag, "_tx_data"},    tx_data,    0);
        check_eq({tag, "_rx_ready"},   rx_ready,   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned rd_cnt;
        int unsigned bad_valid;
        int unsigned bad_data;
        int unsigned bad_ready;

        rst_n      = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        tx_ready   = 1'b0;
        read_data  = 8'h00;
        data_ready = 1'b0;
        write_done = 1'b0;
        tick();
        tick();
        check_reset_outputs("por");
        rst_n = 1'b1;
        tick();
        check_eq("por_rx_ready_after", rx_ready, 1);

        // Write: 0x83 then 0x5A
        send_byte(8'h83);
        check_eq("wr_busy_getdata", busy, 1);
        check_eq("wr_rx_ready_getdata", rx_ready, 1);
        send_byte(8'h5A);
        check_eq("wr_en", write_en, 1);
        check_eq("wr_addr", addr, 3);
        check_eq("wr_data", write_data, 8'h5A);
        check_eq("wr_rx_ready_low", rx_ready, 0);
        tick();
        check_eq("wr_en_one_cycle", write_en, 0);
        check_eq("wr_wait_busy", busy, 1);
        check_eq("wr_addr_hold", addr, 3);
        write_done = 1'b1;
        tick();
        write_done = 1'b0;
        check_eq("wr_done_idle", busy, 0);
        check_eq("wr_no_tx", tx_valid, 0);
        check_eq("wr_rx_ready_back", rx_ready, 1);

        // Read: 0x07, data_ready in 4th read_en cycle
        send_byte(8'h07);
        check_eq("rd_en_latency", read_en, 1);
        check_eq("rd_addr", addr, 7);
        rd_cnt = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (read_en) rd_cnt++;
        end
        data_ready = 1'b1;
        read_data  = 8'hC3;
        tick();
        data_ready = 1'b0;
        read_data  = 8'h00;
        check_eq("rd_en_cycles", rd_cnt, 4);
        check_eq("rd_en_drop", read_en, 0);
        check_eq("rd_tx_valid", tx_valid, 1);
        check_eq("rd_tx_data", tx_data, 8'hC3);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check_eq("rd_tx_done", tx_valid, 0);
        check_eq("rd_idle", busy, 0);
        tick();
        check_eq("rd_tx_once", tx_valid, 0);

        // Backpressure: read returns 0x11, tx_ready low 10 cycles
        send_byte(8'h02);
        data_ready = 1'b1;
        read_data  = 8'h11;
        tick();
        data_ready = 1'b0;
        read_data  = 8'hFF;
        rx_valid   = 1'b1;
        rx_data    = 8'h81;
        bad_valid = 0;
        bad_data  = 0;
        bad_ready = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_valid !== 1'b1) bad_valid++;
            if (tx_data !== 8'h11) bad_data++;
            if (rx_ready !== 1'b0) bad_ready++;
            tick();
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        check_eq("bp_tx_valid_stable", bad_valid, 0);
        check_eq("bp_tx_data_stable", bad_data, 0);
        check_eq("bp_rx_ready_low", bad_ready, 0);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check_eq("bp_tx_done", tx_valid, 0);
        check_eq("bp_no_cmd_taken", busy, 0);

        // Reset in the middle of a write command
        send_byte(8'h85);
        check_eq("rst_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("midrst_rx_ready_hold", rx_ready, 0);
        tick();
        check_eq("midrst_rx_ready_up", rx_ready, 1);
        tick();
        tick();
        check_eq("midrst_no_txn_busy", busy, 0);
        send_byte(8'h42);
        check_eq("midrst_read_en", read_en, 1);
        check_eq("midrst_addr", addr, 2);
        data_ready = 1'b1;
        read_data  = 8'h5C;
        tick();
        data_ready = 1'b0;
        read_data  = 8'h00;
        check_eq("midrst_tx_data", tx_data, 8'h5C);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;

        // Stray strobes in IDLE
        write_done = 1'b1;
        data_ready = 1'b1;
        read_data  = 8'h99;
        tick();
        write_done = 1'b0;
        data_ready = 1'b0;
        read_data  = 8'h00;
        check_eq("stray_busy", busy, 0);
        check_eq("stray_tx_valid", tx_valid, 0);
        check_eq("stray_rx_ready", rx_ready, 1);
        check_eq("stray_read_en", read_en, 0);
        tick();
        check_eq("stray_tx_valid_later", tx_valid, 0);

`ifdef CMD_BRIDGE_TIMEOUT_EN
        // Read timeout: addr 1, no data_ready
        send_byte(8'h01);
        rd_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (tx_valid) break;
            if (read_en) rd_cnt++;
            tick();
        end
        check_eq("to_rd_en_cycles", rd_cnt, 20);
        check_eq("to_rd_tx_valid", tx_valid, 1);
        check_eq("to_rd_tx_data", tx_data, 8'hEE);
        check_eq("to_rd_read_en_low", read_en, 0);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;

        // Write timeout: no write_done
        send_byte(8'h81);
        send_byte(8'hAA);
        for (int i = 0; i < 40; i++) begin
            if (tx_valid) break;
            tick();
        end
        check_eq("to_wr_tx_valid", tx_valid, 1);
        check_eq("to_wr_tx_data", tx_data, 8'hEE);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check_eq("to_wr_idle", busy, 0);
`endif

        tick();
        check_eq("excl_rd_wr", both_cnt, 0);
        check_eq("wr_en_total_cycles", wr_cycles, EXP_WR_CYCLES);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
